// File: rtl/c3_heap_arbiter.sv
// Two-port round-robin front end for the shared C3 heap unit.
// Keeps a shadow occupancy count and a watchdog on unit busy.
module c3_heap_arbiter #(
    parameter int HEAP_DEPTH = 32,
    parameter int CNT_W      = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_v,
    input  logic [4:0]       req0_rd,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_v,
    input  logic [4:0]       req1_rd,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic             rsp0_v,
    output logic [4:0]       rsp0_rd,
    output logic [31:0]      rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_v,
    output logic [4:0]       rsp1_rd,
    output logic [31:0]      rsp1_data,
    output logic             rsp1_err,
    output logic             unit_in_v,
    output logic [4:0]       unit_rd,
    output logic [31:0]      unit_in_data,
    input  logic             unit_out_v,
    input  logic [31:0]      unit_out_data,
    input  logic             unit_busy,
    output logic [CNT_W-1:0] occupancy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ARM, WAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              prio_q, prio_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              rsp0_v_q, rsp0_v_d;
    logic [4:0]        rsp0_rd_q, rsp0_rd_d;
    logic [31:0]       rsp0_data_q, rsp0_data_d;
    logic              rsp0_err_q, rsp0_err_d;
    logic              rsp1_v_q, rsp1_v_d;
    logic [4:0]        rsp1_rd_q, rsp1_rd_d;
    logic [31:0]       rsp1_data_q, rsp1_data_d;
    logic              rsp1_err_q, rsp1_err_d;

    logic              grant0, grant1, idle_ok;
    logic              fire, f_owner, f_err;
    logic [4:0]        f_rd, acc_rd;
    logic [31:0]       f_data, acc_data;
    logic              is_push, full, empty;

    // prio_q=1 means req1 wins a tie
    assign grant0     = req0_v && (!req1_v || !prio_q);
    assign grant1     = req1_v && !grant0;
    assign idle_ok    = (state_q == IDLE) && !unit_busy;
    assign req0_ready = idle_ok && grant0;
    assign req1_ready = idle_ok && grant1;

    assign acc_rd   = grant1 ? req1_rd : req0_rd;
    assign acc_data = grant1 ? req1_data : req0_data;
    assign is_push  = (acc_rd == 5'd0);
    assign full     = (occ_q == CNT_W'(HEAP_DEPTH));
    assign empty    = (occ_q == '0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rd_d    = rd_q;
        data_d  = data_q;
        occ_d   = occ_q;
        prio_d  = prio_q;
        wd_d    = wd_q;
        fire    = 1'b0;
        f_owner = owner_q;
        f_rd    = rd_q;
        f_data  = '0;
        f_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (idle_ok && (grant0 || grant1)) begin
                    prio_d = grant0;
                    if ((is_push && full) || (!is_push && empty)) begin
                        // Rejected locally: the unit never sees it
                        fire    = 1'b1;
                        f_owner = grant1;
                        f_rd    = acc_rd;
                        f_err   = 1'b1;
                    end else begin
                        owner_d = grant1;
                        rd_d    = acc_rd;
                        data_d  = acc_data;
                        occ_d   = is_push ? occ_q + 1'b1 : occ_q - 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = ARM;
            ARM: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wd_q == WD_W'(TIMEOUT)) begin
                    fire    = 1'b1;
                    f_err   = 1'b1;
                    state_d = IDLE;
                end else if (!unit_busy) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                    if (rd_q != 5'd0) begin
                        if (unit_out_v) begin
                            f_data = unit_out_data;
                        end else begin
                            // Unit had nothing: shadow count was wrong
                            f_err = 1'b1;
                            occ_d = '0;
                        end
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp0_v_d    = 1'b0;
        rsp0_rd_d   = rsp0_rd_q;
        rsp0_data_d = rsp0_data_q;
        rsp0_err_d  = rsp0_err_q;
        rsp1_v_d    = 1'b0;
        rsp1_rd_d   = rsp1_rd_q;
        rsp1_data_d = rsp1_data_q;
        rsp1_err_d  = rsp1_err_q;
        if (fire && !f_owner) begin
            rsp0_v_d    = 1'b1;
            rsp0_rd_d   = f_rd;
            rsp0_data_d = f_data;
            rsp0_err_d  = f_err;
        end
        if (fire && f_owner) begin
            rsp1_v_d    = 1'b1;
            rsp1_rd_d   = f_rd;
            rsp1_data_d = f_data;
            rsp1_err_d  = f_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            occ_q       <= '0;
            prio_q      <= 1'b0;
            wd_q        <= '0;
            rsp0_v_q    <= 1'b0;
            rsp0_rd_q   <= '0;
            rsp0_data_q <= '0;
            rsp0_err_q  <= 1'b0;
            rsp1_v_q    <= 1'b0;
            rsp1_rd_q   <= '0;
            rsp1_data_q <= '0;
            rsp1_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            occ_q       <= occ_d;
            prio_q      <= prio_d;
            wd_q        <= wd_d;
            rsp0_v_q    <= rsp0_v_d;
            rsp0_rd_q   <= rsp0_rd_d;
            rsp0_data_q <= rsp0_data_d;
            rsp0_err_q  <= rsp0_err_d;
            rsp1_v_q    <= rsp1_v_d;
            rsp1_rd_q   <= rsp1_rd_d;
            rsp1_data_q <= rsp1_data_d;
            rsp1_err_q  <= rsp1_err_d;
        end
    end

    assign unit_in_v    = (state_q == ISSUE);
    assign unit_rd      = unit_in_v ? rd_q : '0;
    assign unit_in_data = unit_in_v ? data_q : '0;

    assign rsp0_v    = rsp0_v_q;
    assign rsp0_rd   = rsp0_rd_q;
    assign rsp0_data = rsp0_data_q;
    assign rsp0_err  = rsp0_err_q;
    assign rsp1_v    = rsp1_v_q;
    assign rsp1_rd   = rsp1_rd_q;
    assign rsp1_data = rsp1_data_q;
    assign rsp1_err  = rsp1_err_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_c3_heap_arbiter.sv
// Directed bench for c3_heap_arbiter with a behavioural max-heap unit stub.
module tb_c3_heap_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_v = 1'b0, req1_v = 1'b0;
  logic [4:0]  req0_rd = '0, req1_rd = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_v, rsp1_v, rsp0_err, rsp1_err;
  logic [4:0]  rsp0_rd, rsp1_rd;
  logic [31:0] rsp0_data, rsp1_data;
  logic        unit_in_v;
  logic [4:0]  unit_rd;
  logic [31:0] unit_in_data;
  logic        st_out_v = 1'b0;
  logic [31:0] st_out_data = '0;
  logic        st_busy = 1'b0;
  logic [5:0]  occupancy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c3_heap_arbiter #(.HEAP_DEPTH(32), .CNT_W(6), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req0_v(req0_v), .req0_rd(req0_rd), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_v(req1_v), .req1_rd(req1_rd), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rsp0_v(rsp0_v), .rsp0_rd(rsp0_rd), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .rsp1_v(rsp1_v), .rsp1_rd(rsp1_rd), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .unit_in_v(unit_in_v), .unit_rd(unit_rd),
    .unit_in_data(unit_in_data),
    .unit_out_v(st_out_v), .unit_out_data(st_out_data),
    .unit_busy(st_busy), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  int          busy_len = 1;
  int          st_cnt = 0;
  logic        st_pop = 1'b0;
  logic [31:0] st_val = '0;
  logic [31:0] heap[$];

  always @(posedge clk) begin
    st_out_v <= 1'b0;
    if (reset) begin
      st_busy <= 1'b0;
      st_cnt  <= 0;
      heap.delete();
    end else if (!st_busy && unit_in_v) begin
      st_busy <= 1'b1;
      st_cnt  <= busy_len;
      st_pop  <= (unit_rd != 5'd0);
      st_val  <= unit_in_data;
    end else if (st_busy) begin
      if (st_cnt <= 1) begin
        st_busy <= 1'b0;
        if (st_pop) begin
          int mi;
          mi = -1;
          for (int i = 0; i < heap.size(); i++)
            if (mi < 0 || heap[i] > heap[mi]) mi = i;
          st_out_v    <= 1'b1;
          st_out_data <= (mi < 0) ? 32'd0 : heap[mi];
          if (mi >= 0) heap.delete(mi);
        end else begin
          heap.push_back(st_val);
        end
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  typedef struct {
    logic        p;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          in_cnt = 0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;
  int          rsp_cyc = 0;
  int          acc_cyc = 0;

  always @(negedge clk) begin
    if (unit_in_v) begin
      in_cnt++;
      last_rd   = unit_rd;
      last_data = unit_in_data;
    end
    if (rsp0_v || rsp1_v) begin
      exp_t e;
      rsp_cyc = cyc;
      chk("rsp_excl", (rsp0_v & rsp1_v) === 1'b0);
      chk("sb_nonempty", sb.size() != 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_port", rsp1_v === e.p);
        chk("rsp_rd", (rsp1_v ? rsp1_rd : rsp0_rd) === e.rd);
        chk("rsp_data", (rsp1_v ? rsp1_data : rsp0_data) === e.data);
        chk("rsp_err", (rsp1_v ? rsp1_err : rsp0_err) === e.err);
      end
    end
  end

  task automatic drive(input bit p, input bit v,
                       input logic [4:0] rd, input logic [31:0] d);
    if (p) begin
      req1_v = v; req1_rd = rd; req1_data = d;
    end else begin
      req0_v = v; req0_rd = rd; req0_data = d;
    end
  endtask

  task automatic issue(input bit p, input logic [4:0] rd,
                       input logic [31:0] d, input logic [31:0] ed,
                       input logic ee);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, rd, d);
    for (int i = 0; i < 400 && !got; i++) begin
      #1;
      if (p ? req1_ready : req0_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
        sb.push_back('{p, rd, ed, ee});
      end
      @(negedge clk);
    end
    drive(p, 1'b0, 5'd0, 32'd0);
    chk("accept", got == 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", sb.size() == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  int in0;
  int t0;
  bit got;
  bit g;

  initial begin
    #500000;
    $display("FAIL global_timeout obs=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp0_v", rsp0_v === 1'b0);
    chk("rst_rsp1_v", rsp1_v === 1'b0);
    chk("rst_unit_in_v", unit_in_v === 1'b0);
    chk("rst_occ", occupancy === 6'd0);
    chk("rst_rsp0_data", rsp0_data === 32'd0);
    reset = 1'b0;

    in0 = in_cnt;
    issue(0, 5'd0, 32'd7, 32'd0, 1'b0);
    drain();
    chk("push_lat", (rsp_cyc - acc_cyc) == 4);
    chk("push_in_cnt", (in_cnt - in0) == 1);
    chk("push_unit_rd", last_rd === 5'd0);
    chk("push_unit_data", last_data === 32'd7);
    chk("push_occ", occupancy === 6'd1);

    do_reset();
    issue(0, 5'd0, 32'd5, 32'd0, 1'b0);
    issue(0, 5'd0, 32'd9, 32'd0, 1'b0);
    issue(0, 5'd0, 32'd3, 32'd0, 1'b0);
    issue(1, 5'd10, 32'd0, 32'd9, 1'b0);
    issue(1, 5'd10, 32'd0, 32'd5, 1'b0);
    issue(1, 5'd10, 32'd0, 32'd3, 1'b0);
    drain();
    chk("pop_unit_rd", last_rd === 5'd10);
    chk("pop_occ", occupancy === 6'd0);

    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 5'd0, 32'd100);
    drive(1, 1'b1, 5'd0, 32'd200);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          g = req1_ready;
          chk("grant_order", g === k[0]);
          sb.push_back('{g, 5'd0, 32'd0, 1'b0});
        end
        @(negedge clk);
      end
      chk("grant_seen", got == 1'b1);
    end
    drive(0, 1'b0, 5'd0, 32'd0);
    drive(1, 1'b0, 5'd0, 32'd0);
    drain();
    chk("rr_occ", occupancy === 6'd4);

    do_reset();
    in0 = in_cnt;
    issue(0, 5'd5, 32'd0, 32'd0, 1'b1);
    drain();
    chk("under_lat", (rsp_cyc - acc_cyc) == 1);
    chk("under_in_cnt", (in_cnt - in0) == 0);
    chk("under_occ", occupancy === 6'd0);

    in0 = in_cnt;
    for (int i = 0; i < 32; i++)
      issue(i[0], 5'd0, 32'(i + 1), 32'd0, 1'b0);
    drain();
    chk("full_occ", occupancy === 6'd32);
    issue(1, 5'd0, 32'd99, 32'd0, 1'b1);
    drain();
    chk("over_lat", (rsp_cyc - acc_cyc) == 1);
    chk("over_in_cnt", (in_cnt - in0) == 32);
    chk("over_occ", occupancy === 6'd32);

    do_reset();
    busy_len = 300;
    issue(0, 5'd0, 32'd1, 32'd0, 1'b1);
    t0 = acc_cyc;
    drain();
    busy_len = 1;
    chk("wd_lat", (rsp_cyc - t0) == 259);
    chk("wd_still_busy", st_busy === 1'b1);
    @(negedge clk);
    drive(1, 1'b1, 5'd0, 32'd2);
    #1;
    chk("wd_blocked", req1_ready === 1'b0);
    drive(1, 1'b0, 5'd0, 32'd0);
    issue(1, 5'd0, 32'd2, 32'd0, 1'b0);
    chk("wd_after_busy", (acc_cyc - t0) == 302);
    drain();
    chk("wd_occ", occupancy === 6'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
